cacheline_adaptor: RTL
======================

// Module: cacheline_adaptor
// PURPOSE
//  Memory-side responder for the cache's pmem interface. Accepts one
//  whole-line read or write request from cache_control and services it
//  as a burst of BURSTS beats on the physical-memory bus.
//  Returns one resp_o pulse per completed line transfer.
//  Sits between cache datapath/control and physical memory.
// PARAMETERS
//  LINE_WIDTH   256  cache line width in bits
//  BURST_WIDTH  64   memory bus beat width in bits
//  ADDR_WIDTH   32   address width
//  BURSTS       LINE_WIDTH/BURST_WIDTH (derived localparam, 4). Beat counter is $clog2(BURSTS) bits.
// PORTS
//  clk        in   1           clock, all state updates on posedge
//  rst        in   1           synchronous active-high reset
//  address_i  in   ADDR_WIDTH  line address from cache
//  read_i     in   1           cache line-read request (pmem_read)
//  write_i    in   1           cache line-write request (pmem_write)
//  line_i     in   LINE_WIDTH  line to write (pmem_wdata)
//  line_o     out  LINE_WIDTH  line read data (pmem_rdata)
//  resp_o     out  1           line transfer done (pmem_resp)
//  address_o  out  ADDR_WIDTH  memory burst address
//  read_o     out  1           memory burst read request
//  write_o    out  1           memory burst write request
//  burst_o    out  BURST_WIDTH write beat data
//  burst_i    in   BURST_WIDTH read beat data
//  resp_i     in   1           memory beat valid/accepted
// BEHAVIOUR
//  Reset: state=s_idle, count=0, addr_buf=0, line_buf=0.
//   All outputs are 0 the cycle after rst is sampled high.
//  States: s_idle, s_read, s_write, s_done. Encoding is left to the
//   implementer. Outputs are decoded from registered state only.
//  s_idle:
//   - Outputs low.
//   - read_i=1: latch addr_buf<=address_i, count<=0, go to s_read.
//   - Else write_i=1: latch addr_buf, line_buf<=line_i, count<=0,
//     go to s_write.
//   - read_i and write_i both high: read wins; write is ignored.
//  s_read:
//   - read_o=1, address_o=addr_buf.
//   - Each cycle with resp_i=1: line_buf[count*BW +: BW]<=burst_i,
//     count++.
//   - Beat with count==BURSTS-1: go to s_done.
//   - resp_i=0 cycles stall; beats need not be contiguous.
//  s_write:
//   - write_o=1, address_o=addr_buf,
//     burst_o=line_buf[count*BW +: BW].
//   - resp_i=1 accepts the beat, count++.
//   - Last beat accepted: go to s_done.
//  s_done:
//   - resp_o=1 for exactly one cycle, read_o=write_o=0.
//   - Always go to s_idle.
//   - cache_control must drop read_i/write_i by the following cycle.
//  Ports outside the active state:
//   - line_o=line_buf at all times; valid when resp_o=1 after a read.
//   - burst_o=0 outside s_write.
//   - address_o=0 in s_idle and s_done.
//  Latency: request seen at edge N. read_o/write_o high from cycle N+1.
//   resp_o is high in the cycle after the last resp_i beat.
//  Request inputs are ignored outside s_idle; address and data are latched.
//  resp_i in s_idle/s_done is ignored.
//  count wraps BURSTS-1 -> 0 on the last beat.
//  rst mid-burst: transfer abandoned, no resp_o, back to s_idle.
// CONFIGURATION
//  CACHELINE_ADAPTOR_ALIGN_EN defined:
//   address_o low $clog2(LINE_WIDTH/8) bits forced to 0 (line aligned).
//  Not defined: address_o=addr_buf unmodified.
// TESTING
//  Reset: rst=1 for 2 cycles mid-write -> all outputs 0, no resp_o,
//   accepts a new read immediately.
//  Read: address_i=0x0000_1040, read_i=1.
//   Memory gives beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on
//   consecutive resp_i.
//   -> line_o=0x44..44_33..33_22..22_11..11.
//   -> resp_o high exactly one cycle, the cycle after beat 4.
//  Write: line_i=0xDDDD..CCCC..BBBB..AAAA, write_i=1, resp_i with 2
//   idle gaps.
//   -> burst_o=0xAAAA.., 0xBBBB.., 0xCCCC.., 0xDDDD.. in order.
//   -> each beat held through its stall; write_o=1 until the last
//      beat; then one resp_o.
//  Simultaneous read_i=write_i=1 -> read burst only, write_o never 1.
//  Spurious resp_i in s_idle -> no state change, count stays 0.
//  Align: address_i=0x0000_105C.
//   -> with CACHELINE_ADAPTOR_ALIGN_EN, address_o=0x0000_1040.
//   -> without it, address_o=0x0000_105C.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// Cache-line to memory-burst adaptor: one line read/write becomes BURSTS beats on the pmem bus.
// Optional macro CACHELINE_ADAPTOR_ALIGN_EN forces address_o to a line-aligned address.
module cacheline_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  output logic                   resp_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  output logic [BURST_WIDTH-1:0] burst_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  input  logic                   resp_i
);

  // state   | meaning
  // s_idle  | waiting for a line request from the cache
  // s_read  | collecting read beats into line_buf
  // s_write | presenting write beats from line_buf
  // s_done  | one-cycle line-complete response

  localparam int BURSTS = LINE_WIDTH / BURST_WIDTH;
  localparam int CW     = (BURSTS > 1) ? $clog2(BURSTS) : 1;
  localparam int OFF    = $clog2(LINE_WIDTH / 8);
  localparam logic [CW-1:0] LAST = CW'(BURSTS - 1);

  typedef enum logic [1:0] {
    s_idle,
    s_read,
    s_write,
    s_done
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [ADDR_WIDTH-1:0]  addr_buf, addr_d;
  logic [LINE_WIDTH-1:0]  line_buf, line_d;
  logic [ADDR_WIDTH-1:0]  addr_out_d;
  logic [BURST_WIDTH-1:0] burst_d;
  logic                   read_d, write_d, resp_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_buf;
    line_d  = line_buf;
    case (state_q)
      s_idle: begin
        if (read_i) begin
          addr_d  = address_i;
          count_d = '0;
          state_d = s_read;
        end else if (write_i) begin
          addr_d  = address_i;
          line_d  = line_i;
          count_d = '0;
          state_d = s_write;
        end
      end
      s_read: begin
        if (resp_i) begin
          line_d[count_q*BURST_WIDTH +: BURST_WIDTH] = burst_i;
          count_d = count_q + 1'b1;
          if (count_q == LAST) state_d = s_done;
        end
      end
      s_write: begin
        if (resp_i) begin
          count_d = count_q + 1'b1;
          if (count_q == LAST) state_d = s_done;
        end
      end
      s_done:  state_d = s_idle;
      default: state_d = s_idle;
    endcase
  end

  // Outputs are registered from next-state values so they line up with state_q.
  always_comb begin
    read_d  = (state_d == s_read);
    write_d = (state_d == s_write);
    resp_d  = (state_d == s_done);
    addr_out_d = '0;
    if (read_d || write_d) begin
`ifdef CACHELINE_ADAPTOR_ALIGN_EN
      addr_out_d = {addr_d[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
`else
      addr_out_d = addr_d;
`endif
    end
    burst_d = '0;
    if (write_d) burst_d = line_d[count_d*BURST_WIDTH +: BURST_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= s_idle;
      count_q   <= '0;
      addr_buf  <= '0;
      line_buf  <= '0;
      line_o    <= '0;
      resp_o    <= 1'b0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      burst_o   <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      addr_buf  <= addr_d;
      line_buf  <= line_d;
      line_o    <= line_d;
      resp_o    <= resp_d;
      address_o <= addr_out_d;
      read_o    <= read_d;
      write_o   <= write_d;
      burst_o   <= burst_d;
    end
  end

endmodule
